// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage boundary with a two-entry
// skid buffer, synchronous flush and bubble masking of control bits.
// Ports:
//   CLOCK, RESET (async, active-high), Flush (sync)
//   In_Valid/In_Ready + Ctrl_In/Data_In/Addr_In  : upstream beat
//   Out_Valid/Out_Ready + Ctrl_Out/Data_Out/Addr_Out : main entry
//   Occupancy : stored beats (0..2)
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int NUM_DATA = 2,
  parameter int CTRL_W = 3,
  parameter int ADDR_W = 5,
  parameter logic [CTRL_W-1:0] CTRL_KILL_MASK = {CTRL_W{1'b1}}
) (
  input  logic                       CLOCK,
  input  logic                       RESET,
  input  logic                       Flush,
  input  logic                       In_Valid,
  output logic                       In_Ready,
  input  logic [CTRL_W-1:0]          Ctrl_In,
  input  logic [NUM_DATA*DATA_W-1:0] Data_In,
  input  logic [ADDR_W-1:0]          Addr_In,
  output logic                       Out_Valid,
  input  logic                       Out_Ready,
  output logic [CTRL_W-1:0]          Ctrl_Out,
  output logic [NUM_DATA*DATA_W-1:0] Data_Out,
  output logic [ADDR_W-1:0]          Addr_Out,
  output logic [1:0]                 Occupancy
);

  localparam int DW = NUM_DATA * DATA_W;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DW-1:0]     data;
    logic [ADDR_W-1:0] addr;
  } beat_t;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t st_q, st_d;
  logic   rdy_q;
  beat_t  main_q, skid_q, in_b;
  logic   acc, ret;
  logic   ld_main, ld_skid, mv_skid;

  assign in_b      = '{ctrl: Ctrl_In, data: Data_In, addr: Addr_In};
  assign In_Ready  = rdy_q;
  assign Out_Valid = (st_q != EMPTY);
  assign Occupancy = st_q;
  assign acc       = In_Valid & rdy_q;
  assign ret       = Out_Valid & Out_Ready;

  // Empty stage must never present live write-enables downstream.
  assign Ctrl_Out = Out_Valid ? main_q.ctrl
                              : (main_q.ctrl & ~CTRL_KILL_MASK);
  assign Data_Out = main_q.data;
  assign Addr_Out = main_q.addr;

  always_comb begin
    st_d    = st_q;
    ld_main = 1'b0;
    ld_skid = 1'b0;
    mv_skid = 1'b0;
    unique case (st_q)
      EMPTY: begin
        if (acc) begin
          st_d    = ONE;
          ld_main = 1'b1;
        end
      end
      ONE: begin
        if (acc && ret) begin
          ld_main = 1'b1;
        end else if (acc) begin
          st_d    = FULL;
          ld_skid = 1'b1;
        end else if (ret) begin
          st_d = EMPTY;
        end
      end
      FULL: begin
        if (ret) begin
          st_d    = ONE;
          mv_skid = 1'b1;
        end
      end
      default: st_d = EMPTY;
    endcase
    // Flush drops stored beats and any beat offered this cycle.
    if (Flush) begin
      st_d    = EMPTY;
      ld_main = 1'b0;
      ld_skid = 1'b0;
      mv_skid = 1'b0;
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      st_q   <= EMPTY;
      rdy_q  <= 1'b1;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      st_q  <= st_d;
      rdy_q <= (st_d != FULL);
      if (ld_main) begin
        main_q <= in_b;
      end else if (mv_skid) begin
        main_q <= skid_q;
      end
      if (ld_skid) begin
        skid_q <= in_b;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed + random checks of pipe_stage_reg against
// a queue-based model of the stage contents.
module tb_pipe_stage_reg;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        Flush;
  logic        In_Valid;
  logic        Out_Ready;
  logic [2:0]  Ctrl_In;
  logic [4:0]  Addr_In;
  logic [63:0] da_in;
  logic [47:0] db_in;

  logic        a_ir, a_ov, b_ir, b_ov;
  logic [2:0]  a_ctrl, b_ctrl;
  logic [63:0] a_data;
  logic [47:0] b_data;
  logic [4:0]  a_addr, b_addr;
  logic [1:0]  a_occ, b_occ;

  int cmp = 0;
  int errs = 0;

  typedef struct {
    logic [2:0]  c;
    logic [63:0] da;
    logic [47:0] db;
    logic [4:0]  a;
  } beat_t;

  beat_t q[$];

  always #5 CLOCK = ~CLOCK;

  pipe_stage_reg u_a (
    .CLOCK(CLOCK), .RESET(RESET), .Flush(Flush),
    .In_Valid(In_Valid), .In_Ready(a_ir),
    .Ctrl_In(Ctrl_In), .Data_In(da_in), .Addr_In(Addr_In),
    .Out_Valid(a_ov), .Out_Ready(Out_Ready),
    .Ctrl_Out(a_ctrl), .Data_Out(a_data), .Addr_Out(a_addr),
    .Occupancy(a_occ)
  );

  pipe_stage_reg #(
    .DATA_W(16), .NUM_DATA(3), .CTRL_KILL_MASK(3'b001)
  ) u_b (
    .CLOCK(CLOCK), .RESET(RESET), .Flush(Flush),
    .In_Valid(In_Valid), .In_Ready(b_ir),
    .Ctrl_In(Ctrl_In), .Data_In(db_in), .Addr_In(Addr_In),
    .Out_Valid(b_ov), .Out_Ready(Out_Ready),
    .Ctrl_Out(b_ctrl), .Data_Out(b_data), .Addr_Out(b_addr),
    .Occupancy(b_occ)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    cmp++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    int n;
    n = q.size();
    chk({tag, " ov_a"}, a_ov, n > 0);
    chk({tag, " ov_b"}, b_ov, n > 0);
    chk({tag, " occ_a"}, a_occ, n);
    chk({tag, " occ_b"}, b_occ, n);
    chk({tag, " ir_a"}, a_ir, n < 2);
    chk({tag, " ir_b"}, b_ir, n < 2);
    if (n > 0) begin
      chk({tag, " data_a"}, a_data, q[0].da);
      chk({tag, " ctrl_a"}, a_ctrl, q[0].c);
      chk({tag, " addr_a"}, a_addr, q[0].a);
      chk({tag, " data_b"}, b_data, q[0].db);
      chk({tag, " ctrl_b"}, b_ctrl, q[0].c);
    end else begin
      chk({tag, " kill_a"}, a_ctrl, 3'b000);
      chk({tag, " kill_b"}, b_ctrl & 3'b001, 3'b000);
    end
  endtask

  // One clock: decide handshakes from the model, advance on the edge,
  // then compare just after it.
  task automatic cyc(input string tag);
    bit acc, ret;
    beat_t b;
    acc = In_Valid && (q.size() < 2);
    ret = (q.size() > 0) && Out_Ready;
    b = '{c: Ctrl_In, da: da_in, db: db_in, a: Addr_In};
    @(posedge CLOCK);
    if (Flush) begin
      q.delete();
    end else begin
      if (ret) void'(q.pop_front());
      if (acc) q.push_back(b);
    end
    #1;
    check_outs(tag);
  endtask

  task automatic offer(input bit v, input int id);
    In_Valid = v;
    Ctrl_In  = 3'($urandom);
    Addr_In  = 5'(id);
    da_in    = {32'(32'h100 + id), 32'(id)};
    db_in    = {16'(16'h200 + id), 16'(16'h100 + id), 16'(id)};
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " ov"}, {a_ov, b_ov}, 2'b00);
    chk({tag, " ir"}, {a_ir, b_ir}, 2'b11);
    chk({tag, " occ"}, {a_occ, b_occ}, 4'h0);
    chk({tag, " ctrl"}, {a_ctrl, b_ctrl}, 6'h0);
    chk({tag, " data_a"}, a_data, 64'h0);
    chk({tag, " data_b"}, b_data, 64'h0);
    chk({tag, " addr"}, {a_addr, b_addr}, 10'h0);
  endtask

  initial begin
    RESET = 1'b1;
    Flush = 1'b0;
    Out_Ready = 1'($urandom);
    offer(1'($urandom), 17);
    #12;
    check_reset("reset");
    @(negedge CLOCK);
    RESET = 1'b0;
    q.delete();

    // Back-to-back stream of 8 beats.
    Out_Ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      offer(1'b1, i);
      cyc("stream");
    end
    offer(1'b0, 0);
    cyc("stream_end");
    cyc("stream_idle");

    // Stall with skid absorption, then release.
    offer(1'b1, 1);
    cyc("stall_b1");
    Out_Ready = 1'b0;
    offer(1'b1, 2);
    cyc("stall_b2");
    chk("stall_full", a_occ, 2'd2);
    offer(1'b1, 3);
    cyc("stall_hold3");
    cyc("stall_hold3b");
    Out_Ready = 1'b1;
    cyc("rel_1");
    cyc("rel_2");
    offer(1'b0, 0);
    cyc("rel_3");
    cyc("rel_idle");

    // Flush while full, with beat 9 offered.
    Out_Ready = 1'b0;
    offer(1'b1, 4);
    cyc("fl_fill4");
    offer(1'b1, 5);
    cyc("fl_fill5");
    Flush = 1'b1;
    offer(1'b1, 9);
    cyc("flush");
    chk("flush_empty", {a_ov, a_occ}, 3'b000);
    Flush = 1'b0;
    offer(1'b0, 0);
    Out_Ready = 1'b1;
    cyc("flush_after");

    // Bubble masking after popping ctrl 111.
    offer(1'b1, 6);
    Ctrl_In = 3'b111;
    cyc("mask_load");
    offer(1'b0, 0);
    cyc("mask_pop");
    chk("mask_b", b_ctrl, 3'b110);
    chk("mask_a", a_ctrl, 3'b000);

    // Asynchronous reset while full.
    Out_Ready = 1'b0;
    offer(1'b1, 7);
    cyc("ar_fill7");
    offer(1'b1, 8);
    cyc("ar_fill8");
    #2;
    RESET = 1'b1;
    #1;
    check_reset("async_reset");
    q.delete();
    @(negedge CLOCK);
    @(negedge CLOCK);
    RESET = 1'b0;
    Out_Ready = 1'b1;
    offer(1'b1, 10);
    cyc("ar_first");
    chk("ar_lat", a_addr, 5'd10);
    offer(1'b0, 0);
    cyc("ar_drain");

    // Random traffic.
    for (int i = 0; i < 10000; i++) begin
      In_Valid  = ($urandom_range(3) != 0);
      Out_Ready = ($urandom_range(2) != 0);
      Flush     = ($urandom_range(31) == 0);
      Ctrl_In   = 3'($urandom);
      Addr_In   = 5'($urandom);
      da_in     = {$urandom, $urandom};
      db_in     = {16'($urandom), $urandom};
      cyc("rand");
      cmp++;
      assert (b_occ <= 2'd2) else begin
        errs++;
        $error("FAIL occ_bound: observed %0d expected <= 2", b_occ);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
